// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the unified memory port arbiter.
// The arbiter uses the slave view; whatever drives requests and models the memory uses the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_stall;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  m_rvalid, m_rdata,
    output if_rvalid, if_rdata, if_stall,
    output d_rvalid, d_rdata, d_stall,
    output m_req, m_we, m_be, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output m_rvalid, m_rdata,
    input  if_rvalid, if_rdata, if_stall,
    input  d_rvalid, d_rdata, d_stall,
    input  m_req, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between RV32i fetch and load/store stages.
// Data wins contention until MAX_D_BURST back-to-back data grants have held off a waiting fetch.
module mem_port_arbiter #(
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IF,
    GRANT_D,
    RESP
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_D_BURST);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        d_wins;
  logic [3:0]  cnt_inc;

  // Fetch only overrides data once the data streak has reached the limit while fetch waits.
  always_comb begin
    d_wins  = bus.d_req && !(bus.if_req && (cnt_q == BURST_LIMIT));
    cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_be_d      = m_be_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d   = GRANT_D;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_be_d    = bus.d_be;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          cnt_d     = bus.if_req ? cnt_inc : 4'd0;
        end else if (bus.if_req) begin
          state_d   = GRANT_IF;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = 4'b1111;
          m_addr_d  = bus.if_addr;
          m_wdata_d = 32'd0;
          cnt_d     = 4'd0;
        end else begin
          m_req_d   = 1'b0;
        end
      end

      GRANT_IF: begin
        if (bus.m_rvalid) begin
          state_d     = RESP;
          m_req_d     = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.m_rdata;
        end
      end

      GRANT_D: begin
        if (bus.m_rvalid) begin
          state_d    = RESP;
          m_req_d    = 1'b0;
          d_rvalid_d = 1'b1;
          d_rdata_d  = bus.m_rdata;
        end
      end

      // Requests are ignored here so a requester can swap in its next request without a double issue.
      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_be_q      <= 4'b0000;
      m_addr_q    <= 32'd0;
      m_wdata_q   <= 32'd0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_be_q      <= m_be_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.m_req     = m_req_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_be      = m_be_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

  assign bus.if_stall  = bus.if_req && !if_rvalid_q;
  assign bus.d_stall   = bus.d_req && !d_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester and memory agents plus a transaction-level
// reference model of grant order, latency and response steering.
module tb_mem_port_arbiter;

  localparam int MAX_D_BURST = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_D_BURST(MAX_D_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int test_count = 0;
  int fail_count = 0;

  // Stimulus knobs
  int p_if, p_d, p_stray, max_wait;

  // Requester agents
  logic        if_pending, d_pending;
  logic [31:0] if_addr_r, d_addr_r, d_wdata_r;
  logic        d_we_r;
  logic [3:0]  d_be_r;

  // Memory agent
  logic        mem_busy;
  int          mem_cnt;

  // Reference model: memory occupancy, data streak and expected outputs
  logic        occupied, owner_d;
  int          streak;
  logic        exp_m_req, exp_m_we;
  logic [3:0]  exp_m_be;
  logic [31:0] exp_m_addr, exp_m_wdata;
  logic        exp_if_rvalid, exp_d_rvalid;
  logic [31:0] exp_if_rdata, exp_d_rdata;

  logic        log_grants, prev_m_req;
  logic        grant_log [$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    occupied      = 1'b0;
    owner_d       = 1'b0;
    streak        = 0;
    exp_m_req     = 1'b0;
    exp_m_we      = 1'b0;
    exp_m_be      = 4'b0000;
    exp_m_addr    = 32'd0;
    exp_m_wdata   = 32'd0;
    exp_if_rvalid = 1'b0;
    exp_d_rvalid  = 1'b0;
    exp_if_rdata  = 32'd0;
    exp_d_rdata   = 32'd0;
    prev_m_req    = 1'b0;
  endtask

  // One transaction occupies the memory from its grant until one cycle after its response pulse.
  task automatic modelStep();
    logic if_r, d_r;
    if_r = bus.if_req;
    d_r  = bus.d_req;
    exp_if_rvalid = 1'b0;
    exp_d_rvalid  = 1'b0;
    if (!occupied) begin
      if (d_r && !(if_r && streak == MAX_D_BURST)) begin
        occupied    = 1'b1;
        owner_d     = 1'b1;
        exp_m_req   = 1'b1;
        exp_m_we    = bus.d_we;
        exp_m_be    = bus.d_be;
        exp_m_addr  = bus.d_addr;
        exp_m_wdata = bus.d_wdata;
        streak      = if_r ? streak + 1 : 0;
      end else if (if_r) begin
        occupied    = 1'b1;
        owner_d     = 1'b0;
        exp_m_req   = 1'b1;
        exp_m_we    = 1'b0;
        exp_m_be    = 4'hF;
        exp_m_addr  = bus.if_addr;
        exp_m_wdata = 32'd0;
        streak      = 0;
      end
    end else if (exp_m_req) begin
      if (bus.m_rvalid) begin
        exp_m_req = 1'b0;
        if (owner_d) begin
          exp_d_rvalid = 1'b1;
          exp_d_rdata  = bus.m_rdata;
        end else begin
          exp_if_rvalid = 1'b1;
          exp_if_rdata  = bus.m_rdata;
        end
      end
    end else begin
      occupied = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("m_req",     32'(bus.m_req),     32'(exp_m_req));
    checkOutput("m_we",      32'(bus.m_we),      32'(exp_m_we));
    checkOutput("m_be",      32'(bus.m_be),      32'(exp_m_be));
    checkOutput("m_addr",    bus.m_addr,         exp_m_addr);
    checkOutput("m_wdata",   bus.m_wdata,        exp_m_wdata);
    checkOutput("if_rvalid", 32'(bus.if_rvalid), 32'(exp_if_rvalid));
    checkOutput("if_rdata",  bus.if_rdata,       exp_if_rdata);
    checkOutput("d_rvalid",  32'(bus.d_rvalid),  32'(exp_d_rvalid));
    checkOutput("d_rdata",   bus.d_rdata,        exp_d_rdata);
    checkOutput("if_stall",  32'(bus.if_stall),  32'(bus.if_req && !exp_if_rvalid));
    checkOutput("d_stall",   32'(bus.d_stall),   32'(bus.d_req && !exp_d_rvalid));
  endtask

  task automatic driveRequesters();
    bus.if_req  = if_pending;
    bus.if_addr = if_pending ? if_addr_r : $urandom();
    bus.d_req   = d_pending;
    bus.d_we    = d_pending ? d_we_r : 1'($urandom());
    bus.d_be    = d_pending ? d_be_r : 4'($urandom());
    bus.d_addr  = d_pending ? d_addr_r : $urandom();
    bus.d_wdata = d_pending ? d_wdata_r : $urandom();
  endtask

  // Fetch addresses live below 0x8000_0000 and data addresses above, so grants are identifiable.
  task automatic applyStimulus();
    if (bus.if_rvalid) if_pending = 1'b0;
    if (bus.d_rvalid)  d_pending  = 1'b0;
    if (!if_pending && $urandom_range(0, 99) < p_if) begin
      if_pending = 1'b1;
      if_addr_r  = {16'h0000, 14'($urandom()), 2'b00};
    end
    if (!d_pending && $urandom_range(0, 99) < p_d) begin
      d_pending = 1'b1;
      d_we_r    = 1'($urandom());
      d_be_r    = 4'($urandom());
      d_addr_r  = {1'b1, 15'h0000, 16'($urandom())};
      d_wdata_r = $urandom();
    end
    driveRequesters();

    bus.m_rvalid = 1'b0;
    bus.m_rdata  = $urandom();
    if (bus.m_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = $urandom_range(0, max_wait);
      end
      if (mem_cnt == 0) begin
        bus.m_rvalid = 1'b1;
        mem_busy     = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else begin
      mem_busy = 1'b0;
      if ($urandom_range(0, 99) < p_stray) bus.m_rvalid = 1'b1;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
    if (log_grants && bus.m_req && !prev_m_req) grant_log.push_back(bus.m_addr[31]);
    prev_m_req = bus.m_req;
  endtask

  task automatic setMode(input int pi, input int pd, input int ps, input int mw);
    p_if = pi; p_d = pd; p_stray = ps; max_wait = mw;
  endtask

  task automatic doReset();
    rst_n        = 1'b0;
    if_pending   = 1'b0;
    d_pending    = 1'b0;
    mem_busy     = 1'b0;
    mem_cnt      = 0;
    driveRequesters();
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    logic exp_grants [10];
    exp_grants = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    log_grants = 1'b0;
    if_addr_r  = 32'd0;
    d_addr_r   = 32'd0;
    d_wdata_r  = 32'd0;
    d_we_r     = 1'b0;
    d_be_r     = 4'd0;
    setMode(0, 0, 0, 0);

    doReset();
    checkAll();

    // Single fetch with a one-cycle memory response
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    @(posedge clk); #1;
    checkOutput("fetch_m_req",  32'(bus.m_req),     32'd1);
    checkOutput("fetch_m_addr", bus.m_addr,         32'h0000_0040);
    checkOutput("fetch_m_be",   32'(bus.m_be),      32'hF);
    checkOutput("fetch_m_we",   32'(bus.m_we),      32'd0);
    checkOutput("fetch_stall",  32'(bus.if_stall),  32'd1);
    @(negedge clk);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h0051_0093;
    @(posedge clk); #1;
    checkOutput("fetch_rvalid", 32'(bus.if_rvalid), 32'd1);
    checkOutput("fetch_rdata",  bus.if_rdata,       32'h0051_0093);
    checkOutput("fetch_d_rv",   32'(bus.d_rvalid),  32'd0);
    checkOutput("fetch_m_idle", 32'(bus.m_req),     32'd0);
    @(negedge clk);
    bus.m_rvalid = 1'b0;
    bus.if_req   = 1'b0;
    @(posedge clk); #1;
    checkOutput("fetch_pulse_end", 32'(bus.if_rvalid), 32'd0);
    checkOutput("fetch_rdata_hold", bus.if_rdata,      32'h0051_0093);

    // Both requesters saturated: data bursts of MAX_D_BURST, then one fetch
    doReset();
    setMode(100, 100, 0, 0);
    log_grants = 1'b1;
    grant_log.delete();
    repeat (40) stepCycle();
    log_grants = 1'b0;
    checkOutput("grant_count_ok", 32'(grant_log.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      checkOutput($sformatf("grant_order[%0d]", i), 32'(grant_log[i]), 32'(exp_grants[i]));

    // Mixed random traffic with wait states and stray memory responses
    setMode(35, 35, 10, 3);
    repeat (1200) stepCycle();
    setMode(80, 80, 0, 1);
    repeat (400) stepCycle();

    // Let outstanding work drain, then only stray responses with no requests
    setMode(0, 0, 0, 2);
    repeat (20) stepCycle();
    setMode(0, 0, 50, 0);
    repeat (40) stepCycle();

    // Reset mid-store abandons it; the held request is reissued on the first cycle after release
    doReset();
    @(negedge clk);
    d_pending = 1'b1;
    d_we_r    = 1'b1;
    d_be_r    = 4'b0011;
    d_addr_r  = 32'h0000_0100;
    d_wdata_r = 32'hDEAD_BEEF;
    driveRequesters();
    @(posedge clk); #1;
    checkOutput("pre_rst_m_req",  32'(bus.m_req), 32'd1);
    checkOutput("pre_rst_m_be",   32'(bus.m_be),  32'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_m_req",   32'(bus.m_req),    32'd0);
    checkOutput("async_rst_m_we",    32'(bus.m_we),     32'd0);
    checkOutput("async_rst_m_be",    32'(bus.m_be),     32'd0);
    checkOutput("async_rst_m_addr",  bus.m_addr,        32'd0);
    checkOutput("async_rst_m_wdata", bus.m_wdata,       32'd0);
    checkOutput("async_rst_d_rdata", bus.d_rdata,       32'd0);
    @(posedge clk);
    #2;
    rst_n        = 1'b1;
    mem_busy     = 1'b0;
    bus.m_rvalid = 1'b0;
    modelReset();
    setMode(0, 0, 0, 3);
    stepCycle();
    checkOutput("post_rst_issue",  bus.m_addr,  32'h0000_0100);
    checkOutput("post_rst_wdata",  bus.m_wdata, 32'hDEAD_BEEF);
    repeat (30) stepCycle();

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage and the data-memory (load/store) stage of the RV32i pipeline.
- Arbitrates between the two requesters and drives the selected address and payload onto the memory port.
- Steers the read response back to the owning requester and raises stall signals for the hazard logic.
- Data has priority; a burst limit prevents fetch starvation.

Parameters:
MAX_D_BURST, 4, consecutive data grants allowed while IF_REQ is pending before fetch must be granted; legal range 1..15.

Ports:
CLK  in  1  system clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
IF_REQ  in  1  fetch request; held with IF_ADDR until IF_RVALID
IF_ADDR  in  32  fetch byte address
IF_RVALID  out  1  one-cycle pulse: IF_RDATA valid
IF_RDATA  out  32  fetched instruction word
IF_STALL  out  1  IF_REQ && !IF_RVALID
D_REQ  in  1  data request; held with payload until D_RVALID
D_WE  in  1  1 = store, 0 = load
D_BE  in  4  byte enables
D_ADDR  in  32  data byte address
D_WDATA  in  32  store data
D_RVALID  out  1  one-cycle pulse: load data valid / store complete
D_RDATA  out  32  load data
D_STALL  out  1  D_REQ && !D_RVALID
M_REQ  out  1  memory request; held until M_RVALID
M_WE  out  1  memory write enable
M_BE  out  4  memory byte enables
M_ADDR  out  32  memory address
M_WDATA  out  32  memory write data
M_RVALID  in  1  memory completion, one cycle
M_RDATA  in  32  memory read data, valid with M_RVALID

Behaviour:
- Reset (async, RST_N low), all registered outputs:
  - M_REQ, M_WE, M_ADDR, M_WDATA, IF_RVALID, IF_RDATA, D_RVALID, D_RDATA are 0. M_BE is 4'b0000.
  - State is IDLE. Burst counter is 0.
  - Reset mid-transaction abandons it; the memory shares RST_N.
- FSM states: IDLE, GRANT_IF, GRANT_D, RESP.
- IDLE, arbitration sampled each cycle:
  - If D_REQ && !(IF_REQ && cnt == MAX_D_BURST):
    - go to GRANT_D
    - latch D_WE/D_BE/D_ADDR/D_WDATA onto the M_* registers
    - if IF_REQ, cnt++ (saturating); else cnt = 0
  - Else if IF_REQ:
    - go to GRANT_IF
    - latch M_ADDR = IF_ADDR, M_WE = 0, M_BE = 4'b1111, M_WDATA = 0
    - cnt = 0
  - Else stay IDLE; M_REQ = 0.
- GRANT_IF / GRANT_D:
  - M_REQ = 1; M_* are stable and registered.
  - Wait any number of cycles for M_RVALID.
  - On M_RVALID:
    - register M_RDATA into the owner's RDATA
    - set the owner's RVALID = 1
    - M_REQ = 0
    - go to RESP
- RESP, exactly one cycle:
  - The owner's RVALID is 1; the other RVALID is 0.
  - Requester REQ lines are ignored, so a requester may drop or replace its request in this cycle without double issue.
  - Next state is IDLE; RVALID returns to 0.
- The non-owner's RDATA holds its previous value.
- Latency:
  - Request seen in IDLE at cycle t gives M_REQ at t+1.
  - M_RVALID at cycle t+k (k ≥ 1) gives requester RVALID at t+k+1.
  - Minimum 3-cycle issue period per transaction (IDLE, GRANT, RESP).
- Simultaneous IF_REQ and D_REQ: data wins unless the burst limit is reached.
  - After MAX_D_BURST consecutive data grants with fetch waiting, the next arbitration grants fetch.
- M_RVALID in IDLE or RESP is a protocol violation; it is ignored with no state change.
- Requester dropping REQ during GRANT is a protocol violation; the transaction completes and RVALID is still pulsed.
- Stores: D_RVALID marks completion; D_RDATA takes M_RDATA, and its value is don't-care.
- IF_STALL and D_STALL are combinational from REQ and RVALID.

Test Plan:
- Reset: hold RST_N = 0 mid-GRANT_D with M_REQ = 1 -> all outputs 0 asynchronously; after release, state is IDLE and the first D_REQ is issued on cycle 1.
- Single fetch: IF_REQ = 1, IF_ADDR = 0x0000_0040 at t; memory returns 0x0051_0093 at t+1 -> M_REQ/M_ADDR = 0x40, M_BE = 4'hF, M_WE = 0 at t+1; IF_RVALID = 1 and IF_RDATA = 0x0051_0093 at t+2 only.
- Store with a 3-cycle wait: D_WE = 1, D_BE = 4'b0011, D_ADDR = 0x100, D_WDATA = 0xDEAD_BEEF; M_RVALID asserted 3 cycles after M_REQ -> M_* held stable throughout; D_RVALID pulses once; IF_RVALID stays 0.
- Contention: IF_REQ and D_REQ both held continuously, MAX_D_BURST = 4 -> grant order D, D, D, D, IF, D, D, D, D, IF.
- Back-to-back: requester presents a new D_ADDR during the RESP cycle -> the new request is issued exactly once, at RESP+2; no duplicate of the old address.
- Stray M_RVALID = 1 in IDLE with no requests -> no RVALID pulse, state stays IDLE.
